// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit address I2C target; write bytes appear on rx_data/rx_valid, read bytes are fetched via tx_req/tx_data.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] RX_DATA   = 3'd3;
  localparam logic [2:0] RX_ACK    = 3'd4;
  localparam logic [2:0] TX_DATA   = 3'd5;
  localparam logic [2:0] TX_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q, scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] state, cnt;
  logic [7:0] sh;
  logic       sda_low;
  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign sda       = sda_low ? 1'b0 : 1'bz;
  always_ff @(posedge sys_clk or negedge rst)
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  // In the ACK states sda_low doubles as the "ACK already driven" marker: first fall drives, second releases.
  always_ff @(posedge sys_clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      sh       <= 8'h00;
      sda_low  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        cnt     <= 3'd0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sh  <= {sh[6:0], sda_s};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (sh[6:0] == SLAVE_ADDR) begin
                state <= ADDR_ACK;
                rw    <= sda_s;
                busy  <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK, RX_ACK: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
            end else if (state == ADDR_ACK && rw) begin
              state   <= TX_DATA;
              sh      <= tx_data;
              sda_low <= ~tx_data[7];
              cnt     <= 3'd0;
              tx_req  <= 1'b1;
            end else begin
              state   <= RX_DATA;
              sda_low <= 1'b0;
              cnt     <= 3'd0;
            end
          end
          RX_DATA: if (scl_rise) begin
            sh  <= {sh[6:0], sda_s};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              rx_data  <= {sh[6:0], sda_s};
              rx_valid <= 1'b1;
              state    <= RX_ACK;
            end
          end
          TX_DATA: if (scl_fall) begin
            sh      <= {sh[6:0], 1'b0};
            cnt     <= cnt + 3'd1;
            sda_low <= (cnt == 3'd7) ? 1'b0 : ~sh[6];
            if (cnt == 3'd7) state <= TX_ACK;
          end
          TX_ACK: if (scl_rise && sda_s) begin
            state <= WAIT_STOP;
            busy  <= 1'b0;
          end else if (scl_fall) begin
            state   <= TX_DATA;
            sh      <= tx_data;
            sda_low <= ~tx_data[7];
            cnt     <= 3'd0;
            tx_req  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with a transaction-level model and a queue-based scoreboard on rx_valid/tx_req.
module tb_i2c_slave;
  localparam int Q = 50;
  logic       sys_clk, rst, scl, m_low;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, tx_req, rw, busy;
  wire        sda;
  int         total, bad, rx_cnt, tx_cnt;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] buf_d[8];
  logic [7:0] last_rx;
  logic       rx_prev, tx_prev;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup(sda);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .sys_clk(sys_clk), .rst(rst), .scl_in(scl), .sda(sda), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .rw(rw), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor: pops expected bytes whenever the DUT pulses rx_valid or tx_req.
  always @(negedge sys_clk) begin
    if (rst) begin
      if (rx_valid && tx_req) chk("rx_tx_overlap", 8'd1, 8'd0);
      if (rx_valid && rx_prev) chk("rx_valid_width", 8'd2, 8'd1);
      if (tx_req && tx_prev) chk("tx_req_width", 8'd2, 8'd1);
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) chk("rx_unexpected", rx_data, 8'hxx);
        else chk("rx_data", rx_data, exp_rx.pop_front());
      end
      if (tx_req) begin
        tx_cnt++;
        if (exp_tx.size() == 0) chk("tx_unexpected", tx_data, 8'hxx);
        else chk("tx_latch", tx_data, exp_tx.pop_front());
      end
    end
    rx_prev <= rx_valid;
    tx_prev <= tx_req;
  end

  task automatic bit_cycle(input logic b, output logic r);
    m_low = !b; #Q; scl = 1'b1; #Q; r = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
  endtask

  task automatic send_start();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic write_txn(input logic [7:0] a, input int n);
    logic r;
    bit   m;
    m = (a[7:1] == 7'h50);
    send_start();
    send_byte(a);
    bit_cycle(1'b1, r);
    chk("wr_addr_ack", r, !m);
    chk("wr_busy", busy, m);
    if (m) chk("wr_rw", rw, 0);
    for (int k = 0; k < n; k++) begin
      if (m) begin
        exp_rx.push_back(buf_d[k]);
        last_rx = buf_d[k];
      end
      send_byte(buf_d[k]);
      bit_cycle(1'b1, r);
      chk("wr_data_ack", r, !m);
    end
    send_stop();
    chk("wr_busy_stop", busy, 0);
    chk("wr_sda_free", sda, 1);
  endtask

  task automatic read_txn(input logic [7:0] a, input int n);
    logic       r;
    logic [7:0] got;
    bit         m;
    m = (a[7:1] == 7'h50);
    tx_data = buf_d[0];
    if (m) exp_tx.push_back(buf_d[0]);
    send_start();
    send_byte(a);
    bit_cycle(1'b1, r);
    chk("rd_addr_ack", r, !m);
    chk("rd_busy", busy, m);
    if (m) begin
      chk("rd_rw", rw, 1);
      for (int k = 0; k < n; k++) begin
        for (int i = 7; i >= 0; i--) begin
          bit_cycle(1'b1, r);
          got[i] = r;
        end
        chk("rd_byte", got, buf_d[k]);
        if (k < n - 1) begin
          tx_data = buf_d[k + 1];
          exp_tx.push_back(buf_d[k + 1]);
          bit_cycle(1'b0, r);
        end else begin
          bit_cycle(1'b1, r);
          chk("rd_busy_nack", busy, 0);
        end
      end
    end
    send_stop();
    chk("rd_sda_free", sda, 1);
  endtask

  initial begin
    logic       r;
    logic [7:0] b39, a;
    int         c0, t0, n;
    total = 0; bad = 0; rx_cnt = 0; tx_cnt = 0; last_rx = 8'h00;
    rst = 1'b0; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
    #23;
    chk("rst_sda", sda, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    #(2 * Q);
    // Two-byte write to the matching address
    c0 = rx_cnt;
    buf_d[0] = 8'h3C; buf_d[1] = 8'hA5;
    write_txn(8'hA0, 2);
    chk("w2_rx_cnt", 8'(rx_cnt - c0), 8'd2);
    chk("w2_rx_data", rx_data, 8'hA5);
    // Two-byte read, master ACK then NACK
    t0 = tx_cnt;
    buf_d[0] = 8'h96; buf_d[1] = 8'h5A;
    read_txn(8'hA1, 2);
    chk("r2_tx_cnt", 8'(tx_cnt - t0), 8'd2);
    chk("r2_rw", rw, 1);
    // Wrong address: no ACK, no rx_valid, busy stays low
    c0 = rx_cnt;
    buf_d[0] = 8'hFF;
    write_txn(8'hA2, 1);
    chk("nomatch_rx_cnt", 8'(rx_cnt - c0), 8'd0);
    // Partial write byte aborted by repeated START into a read
    c0 = rx_cnt; t0 = tx_cnt;
    send_start();
    send_byte(8'hA0);
    bit_cycle(1'b1, r);
    chk("part_addr_ack", r, 0);
    for (int i = 0; i < 4; i++) bit_cycle(1'($urandom_range(0, 1)), r);
    buf_d[0] = 8'($urandom);
    read_txn(8'hA1, 1);
    chk("part_rx_cnt", 8'(rx_cnt - c0), 8'd0);
    chk("part_rx_data", rx_data, last_rx);
    chk("part_tx_cnt", 8'(tx_cnt - t0), 8'd1);
    // Reset asserted while the slave drives the address ACK
    c0 = rx_cnt;
    send_start();
    send_byte(8'hA0);
    m_low = 1'b0; #(Q / 2);
    chk("rst_ack_low", sda, 0);
    #3 rst = 1'b0;
    #1;
    chk("rst_async_sda", sda, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rw", rw, 0);
    chk("rst_mid_rx_data", rx_data, 8'h00);
    chk("rst_mid_rx_valid", rx_valid, 0);
    chk("rst_mid_tx_req", tx_req, 0);
    last_rx = 8'h00;
    #20 rst = 1'b1;
    #Q scl = 1'b1; #Q; #Q scl = 1'b0; #Q;
    send_byte(8'hA0);
    bit_cycle(1'b1, r);
    chk("nostart_addr_ack", r, 1);
    chk("nostart_busy", busy, 0);
    send_byte(8'h3C);
    bit_cycle(1'b1, r);
    chk("nostart_data_ack", r, 1);
    send_stop();
    chk("nostart_rx_cnt", 8'(rx_cnt - c0), 8'd0);
    // STOP injected during read bit 3 (bit 3 forced to 1 so the bus can rise)
    b39 = 8'($urandom) | 8'h08;
    tx_data = b39;
    exp_tx.push_back(b39);
    send_start();
    send_byte(8'hA1);
    bit_cycle(1'b1, r);
    chk("stop_tx_addr_ack", r, 0);
    for (int i = 7; i >= 4; i--) begin
      bit_cycle(1'b1, r);
      chk("stop_tx_bit", r, b39[i]);
    end
    send_stop();
    chk("stop_tx_sda", sda, 1);
    chk("stop_tx_busy", busy, 0);
    send_byte(8'hA0);
    bit_cycle(1'b1, r);
    chk("idle_ignore_ack", r, 1);
    send_stop();
    // Randomized transactions against the model
    for (int t = 0; t < 24; t++) begin
      a[7:1] = ($urandom_range(0, 3) != 0) ? 7'h50 : 7'($urandom);
      a[0]   = 1'($urandom_range(0, 1));
      n      = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) buf_d[k] = 8'($urandom);
      if (a[0]) read_txn(a, n);
      else write_txn(a, n);
      chk("rand_rx_data", rx_data, last_rx);
    end
    #(4 * Q);
    chk("rx_queue_empty", 8'(exp_rx.size()), 8'd0);
    chk("tx_queue_empty", 8'(exp_tx.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
